cpu_divide: RTL and testbench
=============================

# cpu_divide

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, the counterpart of the CPU multiply unit in the execute stage. A rising edge on `i_latch` starts one operation. Quotient and remainder are produced with fixed latency and announced by a single-cycle `o_ready` pulse. It uses a one-bit-per-cycle restoring algorithm on magnitudes, with sign fix-up and RISC-V special-case handling at the end.

## Interface
- None (no parameters). The datapath is fixed at 32 bits (RV32M).
- `i_clock`  in  1  the single clock.
- `i_reset`  in  1  reset. It is synchronous and active-high.
- `i_latch`  in  1  start request. Only its rising edge is significant.
- `i_signed`  in  1  selects signed (DIV/REM) when 1, unsigned (DIVU/REMU) when 0. Sampled at start.
- `i_numerator`  in  32  dividend. Sampled at start.
- `i_denominator`  in  32  divisor. Sampled at start.
- `o_ready`  out  1  one-cycle pulse: results are valid.
- `o_quotient`  out  32  quotient. Held until the next completion.
- `o_remainder`  out  32  remainder. Held until the next completion.

## Operation
- Start detection:
  - `latch_q` registers `i_latch` every cycle.
  - Start is `i_latch && !latch_q && state == IDLE`.
  - Rising edges in any other state are ignored and not queued.
  - Holding `i_latch` high produces exactly one operation.
- State machine: IDLE -> ITERATE -> FIXUP -> IDLE.
- IDLE, on start:
  - Capture `neg_q = i_signed & (n[31] ^ d[31])` and `neg_r = i_signed & n[31]`.
  - Capture magnitudes: two's-complement negate when `i_signed` and the sign bit is set.
  - Capture raw operands and `i_signed` for special-case checks.
  - Clear the partial remainder; set the counter to 31; go to ITERATE.
- ITERATE, 32 cycles, one per counter value 31..0:
  - Shift the partial remainder left by 1, bringing in the dividend MSB.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - After the step at counter 0, go to FIXUP.
- FIXUP, single cycle, result selection in priority order:
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = raw dividend. This applies to both signed and unsigned.
  - Signed, dividend == 0x80000000 and divisor == 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Otherwise: quotient is negated if `neg_q`; remainder is negated if `neg_r`.
  - Register the results, set `o_ready`, and go to IDLE.
- Magnitudes are 32-bit unsigned. |-2^31| = 0x80000000 is representable, so no widening is needed beyond the 33-bit trial subtract.

## Timing
- Let E0 be the clock edge that samples the start condition.
  - E1..E32 perform the iterations.
  - E33 performs FIXUP and registers the outputs.
- `o_ready` is high for exactly the one cycle between E33 and E34.
- Latency is a constant 33 edges for every operand, including the special cases.
- The earliest next start is sampled at E34, i.e. at the first edge in IDLE. That needs `i_latch` low at or before E33 and high at E34.
- Reset values:
  - state = IDLE, `latch_q` = 0, `o_ready` = 0.
  - `o_quotient` = 0, `o_remainder` = 0.
  - Counter and working registers = 0.
- Reset mid-operation: abort immediately; no `o_ready` pulse; outputs return to 0.
- If `i_latch` is high during reset, the first edge after reset release counts as a rising edge, because `latch_q` resets to 0.
- Operand inputs may change freely after E0 without effect.

## Structure
- Shared CPU package:
  - The state enum (IDLE, ITERATE, FIXUP).
  - Special-case constants: 0x80000000 and 0xFFFFFFFF.
- No sub-module. The restoring step is a local function/combinational block inside `cpu_divide`.
- Width is fixed at 32. The counter is 5 bits.

## Test plan
- Unsigned 100 / 7 -> quotient 14, remainder 2. `o_ready` pulses exactly once, one cycle after E33.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero:
  - Signed 5 / 0 -> quotient 0xFFFFFFFF, remainder 5.
  - Unsigned 0xDEADBEEF / 0 -> quotient 0xFFFFFFFF, remainder 0xDEADBEEF.
- Overflow:
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - The same operands unsigned -> quotient 0, remainder 0x80000000.
- Protocol:
  - `i_latch` held high for 100 cycles -> exactly one `o_ready`.
  - A second rising edge at E10 -> ignored.
  - `i_reset` asserted at E15 -> no `o_ready`; outputs 0; a new start afterwards completes normally.

Source files
------------

// File: rtl/cpu_divide_pkg.sv
// Shared definitions for the CPU divide unit.
//   div_state_t : divider sequencing states
//   INT_MIN     : most negative 32-bit integer, dividend of the signed overflow case
//   NEG_ONE     : all-ones word, divide-by-zero quotient and overflow divisor
//   mag()       : two's-complement magnitude of an operand when treated as signed
package cpu_divide_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        FIXUP   = 2'd2
    } div_state_t;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    // |-2^31| is 0x80000000, which still fits a 32-bit unsigned magnitude.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/cpu_divide.sv
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
// Restoring division on magnitudes, one quotient bit per cycle, followed by a
// single fix-up cycle for signs and the RISC-V special cases. Fixed latency of
// 33 edges from the edge that samples the start to the edge that registers
// the results.
//   i_clock       : clock
//   i_reset       : synchronous active-high reset
//   i_latch       : start request, rising edge only, ignored unless idle
//   i_signed      : 1 = DIV/REM, 0 = DIVU/REMU, sampled at start
//   i_numerator   : dividend, sampled at start
//   i_denominator : divisor, sampled at start
//   o_ready       : one-cycle pulse when results are registered
//   o_quotient    : quotient, held until next completion
//   o_remainder   : remainder, held until next completion
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a rising edge on i_latch
// ITERATE | 32 restoring steps, counter counts 31 down to 0
// FIXUP   | special cases / sign correction, register outputs, pulse ready
module cpu_divide
    import cpu_divide_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_latch,
    input  logic        i_signed,
    input  logic [31:0] i_numerator,
    input  logic [31:0] i_denominator,
    output logic        o_ready,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    div_state_t  state_q;
    div_state_t  state_d;
    logic        latch_q;
    logic        start;
    logic [4:0]  cnt_q;

    logic [31:0] dvd_q;     // dividend magnitude, MSB consumed each step
    logic [31:0] dvs_q;     // divisor magnitude
    logic [31:0] rem_q;     // partial remainder
    logic [31:0] quo_q;     // quotient bits accumulated LSB-first
    logic [31:0] raw_n_q;
    logic [31:0] raw_d_q;
    logic        sgn_q;
    logic        neg_q_q;
    logic        neg_r_q;

    logic [32:0] step_sh;
    logic [32:0] step_diff;
    logic        step_bit;
    logic [31:0] step_rem;

    logic [31:0] fix_quo;
    logic [31:0] fix_rem;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= i_latch;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_latch && !latch_q) begin
                    start   = 1'b1;
                    state_d = ITERATE;
                end
            end
            ITERATE: begin
                if (cnt_q == 5'd0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- restoring step ----------------
    // The partial remainder is always below the divisor, so the shifted value
    // fits in 33 bits and a 33-bit subtract gives the sign of the trial.
    always_comb begin
        step_sh   = {rem_q, dvd_q[31]};
        step_diff = step_sh - {1'b0, dvs_q};
        step_bit  = ~step_diff[32];
        step_rem  = step_bit ? step_diff[31:0] : step_sh[31:0];
    end

    // ---------------- result selection ----------------
    always_comb begin
        fix_quo = neg_q_q ? (~quo_q + 32'd1) : quo_q;
        fix_rem = neg_r_q ? (~rem_q + 32'd1) : rem_q;
        if (raw_d_q == 32'd0) begin
            fix_quo = NEG_ONE;
            fix_rem = raw_n_q;
        end else if (sgn_q && raw_n_q == INT_MIN && raw_d_q == NEG_ONE) begin
            fix_quo = INT_MIN;
            fix_rem = 32'd0;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q       <= 5'd0;
            dvd_q       <= 32'd0;
            dvs_q       <= 32'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            raw_n_q     <= 32'd0;
            raw_d_q     <= 32'd0;
            sgn_q       <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            o_ready     <= 1'b0;
            o_quotient  <= 32'd0;
            o_remainder <= 32'd0;
        end else begin
            o_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        neg_q_q <= i_signed & (i_numerator[31] ^ i_denominator[31]);
                        neg_r_q <= i_signed & i_numerator[31];
                        dvd_q   <= mag(i_numerator, i_signed);
                        dvs_q   <= mag(i_denominator, i_signed);
                        raw_n_q <= i_numerator;
                        raw_d_q <= i_denominator;
                        sgn_q   <= i_signed;
                        rem_q   <= 32'd0;
                        quo_q   <= 32'd0;
                        cnt_q   <= 5'd31;
                    end
                end
                ITERATE: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[30:0], 1'b0};
                    quo_q <= {quo_q[30:0], step_bit};
                    cnt_q <= cnt_q - 5'd1;
                end
                FIXUP: begin
                    o_quotient  <= fix_quo;
                    o_remainder <= fix_rem;
                    o_ready     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_divide.sv
// Self-checking bench for cpu_divide: expected results are pushed to a
// scoreboard when an operation is launched and compared when o_ready pulses.
module tb_cpu_divide;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_latch;
    logic        i_signed;
    logic [31:0] i_numerator;
    logic [31:0] i_denominator;
    logic        o_ready;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    always #5 i_clock = ~i_clock;

    cpu_divide dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_latch       (i_latch),
        .i_signed      (i_signed),
        .i_numerator   (i_numerator),
        .i_denominator (i_denominator),
        .o_ready       (o_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pulses  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model using the language's truncating division.
    task automatic ref_div(input logic s, input logic [31:0] n, input logic [31:0] d,
                           output logic [31:0] q, output logic [31:0] r);
        if (d == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = n;
        end else if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end else begin
            q = n / d;
            r = n % d;
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge i_clock) begin
        exp_t e;
        #1;
        cyc++;
        if (o_ready === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("spurious_ready", {31'd0, o_ready}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", o_quotient, e.q);
                check("remainder", o_remainder, e.r);
                check("latency", cyc, e.cyc);
            end
        end
    end

    // Raise i_latch at a negedge; the next posedge is E0, E33 is 34 monitor ticks on.
    task automatic launch(input logic s, input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        @(negedge i_clock);
        i_signed      = s;
        i_numerator   = n;
        i_denominator = d;
        i_latch       = 1'b1;
        e.q   = q;
        e.r   = r;
        e.cyc = cyc + 34;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge i_clock);
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run(input logic s, input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] q, input logic [31:0] r);
        launch(s, n, d, q, r);
        @(negedge i_clock);
        i_latch       = 1'b0;
        i_numerator   = $urandom;   // operands are free to change after E0
        i_denominator = $urandom;
        i_signed      = ~s;
        wait_done();
        @(negedge i_clock);
    endtask

    initial begin
        logic [31:0] n, d, q, r;
        logic        s;
        int          p0;

        i_reset       = 1'b1;
        i_latch       = 1'b0;
        i_signed      = 1'b0;
        i_numerator   = 32'd0;
        i_denominator = 32'd0;
        repeat (3) @(negedge i_clock);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_quotient", o_quotient, 32'd0);
        check("rst_remainder", o_remainder, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clock);

        // Directed cases from the test plan.
        p0 = pulses;
        run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        repeat (5) @(negedge i_clock);
        check("single_pulse", pulses - p0, 1);
        run(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
        run(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run(1'b0, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
        run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);

        // Random operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            n = $urandom;
            d = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            ref_div(s, n, d, q, r);
            run(s, n, d, q, r);
        end

        // i_latch held high for 100 cycles gives exactly one operation.
        p0 = pulses;
        ref_div(1'b0, 32'd1000, 32'd3, q, r);
        launch(1'b0, 32'd1000, 32'd3, q, r);
        repeat (100) @(negedge i_clock);
        i_latch = 1'b0;
        wait_done();
        repeat (40) @(negedge i_clock);
        check("hold_pulses", pulses - p0, 1);

        // A second rising edge mid-operation is ignored.
        p0 = pulses;
        launch(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        @(negedge i_clock);
        i_latch = 1'b0;
        repeat (8) @(negedge i_clock);
        i_numerator   = 32'd55;
        i_denominator = 32'd5;
        i_latch       = 1'b1;
        @(negedge i_clock);
        i_latch = 1'b0;
        wait_done();
        repeat (40) @(negedge i_clock);
        check("ignored_edge_pulses", pulses - p0, 1);

        // Reset in the middle of an operation.
        p0 = pulses;
        launch(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        @(negedge i_clock);
        i_latch = 1'b0;
        repeat (13) @(negedge i_clock);
        i_reset = 1'b1;
        sb.delete();
        @(negedge i_clock);
        check("midrst_quotient", o_quotient, 32'd0);
        check("midrst_remainder", o_remainder, 32'd0);
        i_reset = 1'b0;
        repeat (45) @(negedge i_clock);
        check("midrst_pulses", pulses - p0, 0);
        run(1'b0, 32'd1234567, 32'd89, 32'd13871, 32'd48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
